regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//   Shares the register file's single write port between two writeback requesters:
//   req0 (ALU writeback) and req1 (load / multi-cycle unit writeback).
//   Uses valid/ready handshakes and round-robin arbitration.
//   Keeps a 32-entry pending-write scoreboard so decode can stall on RAW hazards.
//   Sits between the writeback sources and the register_file write port.
// PARAMETERS
//   DATA_WIDTH  32  width of write data
//   ADDR_WIDTH  5   register index width
//   REG_COUNT   32  number of architectural registers (2**ADDR_WIDTH)
// PORTS
//   clk           in   1   clock, all state updates on posedge
//   reset         in   1   synchronous, active-high
//   clk_enable    in   1   0 = freeze: no handshakes, state held
//   req0_valid    in   1   ALU writeback request
//   req0_rd       in   5   ALU destination register
//   req0_data     in   32  ALU result
//   req0_ready    out  1   req0 accepted this cycle when valid & ready
//   req1_valid    in   1   load/multicycle writeback request
//   req1_rd       in   5   destination register
//   req1_data     in   32  result
//   req1_ready    out  1   req1 accepted this cycle when valid & ready
//   claim_valid   in   1   decode claims a destination register
//   claim_rd      in   5   register being claimed
//   claim_ready   out  1   claim accepted this cycle when valid & ready
//   read_reg_a    in   5   decode source A index for hazard lookup
//   read_reg_b    in   5   decode source B index for hazard lookup
//   busy_a        out  1   pending[read_reg_a]; combinational
//   busy_b        out  1   pending[read_reg_b]; combinational
//   write_enable  out  1   to register_file, registered
//   write_reg_rd  out  5   to register_file, registered
//   write_data    out  32  to register_file, registered
// BEHAVIOUR
//   - Reset: pending = 0; write_enable/write_reg_rd/write_data = 0; last_grant = 1.
//     All readys are 0 while reset = 1. Reset mid-transfer drops the in-flight write.
//   - Arbitration (combinational):
//     - Only one valid: it is granted.
//     - Both valid: grant the requester not equal to last_grant.
//     - After reset, req0 wins the first tie.
//     - reqN_ready = grantN & clk_enable & ~reset.
//     - last_grant updates only on an accepted handshake.
//   - Write port: an accepted handshake at edge T drives the output registers at T.
//     - The write is visible at the outputs during cycle T+1 (latency 1).
//     - write_enable = 1 only if rd != 0; a write to $0 is accepted and silently dropped.
//     - With no handshake, write_enable <= 0; write_reg_rd and write_data hold.
//     - Exactly one write per cycle; an ungranted requester holds valid/rd/data stable.
//   - Scoreboard:
//     - claim_ready = clk_enable & ~reset & (claim_rd == 0 | ~pending[claim_rd]
//       | commit of claim_rd this cycle).
//     - Claim accept sets pending[claim_rd]; $0 is never set.
//     - Write handshake clears pending[rd].
//     - Same-cycle commit and claim of the same rd: the claim wins, bit ends set.
//     - A commit to a non-pending rd is legal (no-op on the scoreboard).
//   - Hazard lookup: busy_x = pending[read_reg_x] from current state, no bypass.
//     busy_x is 0 for $0 and 0 during reset.
//   - clk_enable = 0: all readys are 0; pending and last_grant hold;
//     write_enable <= 0 on the next edge.
// TESTING
//   1. Reset, then req0 valid (rd=5, data=0xDEADBEEF)
//      -> req0_ready=1; next cycle write_enable=1, write_reg_rd=5, write_data=0xDEADBEEF.
//   2. Both requesters valid for 4 cycles (rd=3 and rd=4)
//      -> grants alternate 0,1,0,1; write_reg_rd sequence 3,4,3,4.
//   3. Claim rd=7, then read_reg_a=7 -> busy_a=1 and a second claim of 7 gets claim_ready=0;
//      req1 commits rd=7 -> busy_a=0 next cycle.
//   4. Same cycle: commit rd=9 and claim rd=9 -> both accepted, pending[9]=1 afterwards.
//   5. req0 valid with rd=0, data=0x1234 -> req0_ready=1, write_enable stays 0;
//      claim rd=0 -> busy_a(read_reg_a=0)=0.
//   6. clk_enable=0 with both valid, then reset asserted mid-stream
//      -> no readys, write_enable=0, pending cleared, req0 wins first tie after reset.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the register file's single write port between two writeback
// sources (req0 = ALU, req1 = load / multi-cycle unit) using valid/ready
// handshakes and round-robin arbitration. It also keeps a pending-write
// scoreboard that decode claims destinations in, so decode can stall on
// RAW hazards.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   clk_enable            0 freezes the block: no handshakes, state held
//   req0_*/req1_*         writeback requests (valid/rd/data in, ready out)
//   claim_*               decode claims a destination register
//   read_reg_a/b, busy_a/b  hazard lookup, combinational from current state
//   write_enable, write_reg_rd, write_data
//                         registered write port to the register file
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_rd,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_rd,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  claim_valid,
    input  logic [ADDR_WIDTH-1:0] claim_rd,
    output logic                  claim_ready,
    input  logic [ADDR_WIDTH-1:0] read_reg_a,
    input  logic [ADDR_WIDTH-1:0] read_reg_b,
    output logic                  busy_a,
    output logic                  busy_b,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] write_reg_rd,
    output logic [DATA_WIDTH-1:0] write_data
);

    logic [REG_COUNT-1:0]  pending_q, pending_d;
    // 1 = req1 won the last accepted handshake, 0 = req0 did
    logic                  last_grant_q, last_grant_d;
    logic                  write_enable_q, write_enable_d;
    logic [ADDR_WIDTH-1:0] write_reg_rd_q, write_reg_rd_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

    logic                  active;
    logic                  grant0, grant1;
    logic                  fire0, fire1;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] commit_rd;
    logic [DATA_WIDTH-1:0] commit_data;
    logic                  claim_fire;

    assign active = clk_enable & ~reset;

    // A lone requester always wins; on a tie the one that did not win last.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant_q);
        grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    end

    assign req0_ready = grant0 & active;
    assign req1_ready = grant1 & active;
    assign fire0      = req0_valid & req0_ready;
    assign fire1      = req1_valid & req1_ready;

    always_comb begin
        commit      = fire0 | fire1;
        commit_rd   = '0;
        commit_data = '0;
        if (fire0) begin
            commit_rd   = req0_rd;
            commit_data = req0_data;
        end else if (fire1) begin
            commit_rd   = req1_rd;
            commit_data = req1_data;
        end
    end

    // A claim on a pending register is allowed if that register is being
    // committed in this same cycle; the claim then re-sets the bit.
    assign claim_ready = active & ((claim_rd == '0) | ~pending_q[claim_rd]
                                   | (commit & (commit_rd == claim_rd)));
    assign claim_fire  = claim_valid & claim_ready;

    assign busy_a = ~reset & pending_q[read_reg_a];
    assign busy_b = ~reset & pending_q[read_reg_b];

    // Clear before set so a same-cycle claim of the committed register wins.
    always_comb begin
        pending_d = pending_q;
        if (commit) begin
            pending_d[commit_rd] = 1'b0;
        end
        if (claim_fire) begin
            pending_d[claim_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;

        last_grant_d = last_grant_q;
        if (fire1) begin
            last_grant_d = 1'b1;
        end else if (fire0) begin
            last_grant_d = 1'b0;
        end

        // Writes to $0 are accepted but never raise write_enable.
        write_enable_d = commit & (commit_rd != '0);
        write_reg_rd_d = write_reg_rd_q;
        write_data_d   = write_data_q;
        if (commit) begin
            write_reg_rd_d = commit_rd;
            write_data_d   = commit_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q      <= '0;
            last_grant_q   <= 1'b1;
            write_enable_q <= 1'b0;
            write_reg_rd_q <= '0;
            write_data_q   <= '0;
        end else begin
            pending_q      <= pending_d;
            last_grant_q   <= last_grant_d;
            write_enable_q <= write_enable_d;
            write_reg_rd_q <= write_reg_rd_d;
            write_data_q   <= write_data_d;
        end
    end

    assign write_enable = write_enable_q;
    assign write_reg_rd = write_reg_rd_q;
    assign write_data   = write_data_q;

endmodule
